// File: rtl/watchdog_sequencer.sv
// Multi-requester heartbeat watchdog with a post-timeout grace period before declaring a hang.
// Optional macro WATCHDOG_MISSING_EN enables the per-requester "missing" capture at expiry.
module watchdog_sequencer #(
    parameter int NUM_KICKERS        = 4,
    parameter int COUNTER_WIDTH      = 32,
    parameter int POST_COUNTER_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic [COUNTER_WIDTH-1:0]      timeout_load,
    input  logic [POST_COUNTER_WIDTH-1:0] post_load,
    input  logic [NUM_KICKERS-1:0]        kick_mask,
    input  logic [NUM_KICKERS-1:0]        kick,
    input  logic                          ack,
    output logic                          timeout,
    output logic                          hung,
    output logic [1:0]                    state,
    output logic [NUM_KICKERS-1:0]        missing
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_HUNG    = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic [COUNTER_WIDTH-1:0]      cnt_q, cnt_d;
    logic [POST_COUNTER_WIDTH-1:0] post_q, post_d;
    logic [NUM_KICKERS-1:0]        seen_q, seen_d;
    logic                          timeout_q, timeout_d;
    logic                          hung_q, hung_d;

    logic [NUM_KICKERS-1:0]        seen_or_kick;
    logic                          window_ok;
    logic                          cnt_zero;
    logic                          post_zero;
    logic                          arm_req;
    logic                          idle_arm;
    logic                          reload_evt;
    logic                          expire_evt;
    logic                          release_evt;

    // A window is satisfied when every masked requester has kicked, counting this cycle's kicks.
    assign seen_or_kick = seen_q | kick;
    assign window_ok    = (kick_mask != '0) && ((seen_or_kick & kick_mask) == kick_mask);
    assign cnt_zero     = (cnt_q == '0);
    assign post_zero    = (post_q == '0);
    assign arm_req      = start && !stop;

    assign idle_arm     = (state_q == ST_IDLE) && arm_req;
    assign reload_evt   = (state_q == ST_ARMED) && !stop && (start || window_ok);
    assign expire_evt   = (state_q == ST_ARMED) && !stop && !start && !window_ok && cnt_zero;
    assign release_evt  = (state_q == ST_EXPIRED) && (ack || stop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm_req) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (expire_evt) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                if (release_evt) begin
                    state_d = ST_IDLE;
                end else if (post_zero) begin
                    state_d = ST_HUNG;
                end
            end
            ST_HUNG: begin
                state_d = ST_HUNG;
            end
        endcase
    end

    // Outputs are registered copies of what the next state implies, so they align with state.
    always_comb begin
        timeout_d = (state_d == ST_EXPIRED) || (state_d == ST_HUNG);
        hung_d    = (state_d == ST_HUNG);
    end

    always_comb begin
        cnt_d  = cnt_q;
        seen_d = seen_q;
        post_d = post_q;
        if (idle_arm || reload_evt) begin
            cnt_d  = timeout_load;
            seen_d = '0;
        end else if ((state_q == ST_ARMED) && !stop && !cnt_zero) begin
            cnt_d  = cnt_q - COUNTER_WIDTH'(1);
            seen_d = seen_q | (kick & kick_mask);
        end
        if (expire_evt) begin
            post_d = post_load;
        end else if ((state_q == ST_EXPIRED) && !release_evt && !post_zero) begin
            post_d = post_q - POST_COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            post_q    <= '0;
            seen_q    <= '0;
            timeout_q <= 1'b0;
            hung_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            post_q    <= post_d;
            seen_q    <= seen_d;
            timeout_q <= timeout_d;
            hung_q    <= hung_d;
        end
    end

`ifdef WATCHDOG_MISSING_EN
    logic [NUM_KICKERS-1:0] missing_q, missing_d;

    // Snapshot of laggards at expiry; held through EXPIRED/HUNG/IDLE until the next arm.
    always_comb begin
        missing_d = missing_q;
        if (idle_arm || ((state_q == ST_ARMED) && arm_req)) begin
            missing_d = '0;
        end else if (expire_evt) begin
            missing_d = kick_mask & ~seen_or_kick;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            missing_q <= '0;
        end else begin
            missing_q <= missing_d;
        end
    end

    assign missing = missing_q;
`else
    assign missing = '0;
`endif

    assign timeout = timeout_q;
    assign hung    = hung_q;
    assign state   = state_q;

endmodule

// File: tb/tb_watchdog_sequencer.sv
// Randomized self-checking bench for watchdog_sequencer against a deadline-based reference model.
// Honors WATCHDOG_MISSING_EN so the same bench serves both builds.
module tb_watchdog_sequencer;
    localparam int NK = 4;
    localparam int CW = 32;
    localparam int PW = 8;
`ifdef WATCHDOG_MISSING_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic [CW-1:0] timeout_load;
    logic [PW-1:0] post_load;
    logic [NK-1:0] kick_mask;
    logic [NK-1:0] kick;
    logic          ack;
    logic          timeout;
    logic          hung;
    logic [1:0]    state;
    logic [NK-1:0] missing;

    watchdog_sequencer #(
        .NUM_KICKERS       (NK),
        .COUNTER_WIDTH     (CW),
        .POST_COUNTER_WIDTH(PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .timeout_load(timeout_load),
        .post_load   (post_load),
        .kick_mask   (kick_mask),
        .kick        (kick),
        .ack         (ack),
        .timeout     (timeout),
        .hung        (hung),
        .state       (state),
        .missing     (missing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: the window is an absolute deadline edge, the grace period an absolute hang edge.
    int            m_st;
    longint        now;
    longint        m_deadline;
    longint        m_hang_at;
    logic [NK-1:0] m_seen;
    logic [NK-1:0] m_miss;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, now);
        end
    endtask

    task automatic model_edge();
        logic [NK-1:0] got_all;
        bit            all_in;
        if (reset) begin
            m_st   = 0;
            m_seen = '0;
            m_miss = '0;
        end else begin
            case (m_st)
                0: begin
                    if (start && !stop) begin
                        m_st       = 1;
                        m_deadline = now + 1 + longint'(timeout_load);
                        m_seen     = '0;
                        m_miss     = '0;
                    end
                end
                1: begin
                    got_all = m_seen | kick;
                    all_in  = (kick_mask != 0) && ((got_all & kick_mask) == kick_mask);
                    if (stop) begin
                        m_st = 0;
                    end else if (start) begin
                        m_deadline = now + 1 + longint'(timeout_load);
                        m_seen     = '0;
                        m_miss     = '0;
                    end else if (all_in) begin
                        m_deadline = now + 1 + longint'(timeout_load);
                        m_seen     = '0;
                    end else if (now >= m_deadline) begin
                        m_st      = 2;
                        m_hang_at = now + 1 + longint'(post_load);
                        m_miss    = MISS_EN ? (kick_mask & ~got_all) : '0;
                    end else begin
                        m_seen = m_seen | (kick & kick_mask);
                    end
                end
                2: begin
                    if (ack || stop) m_st = 0;
                    else if (now >= m_hang_at) m_st = 3;
                end
                default: ;
            endcase
        end
        now++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("state", 32'(state), 32'(m_st));
        check_eq("timeout", 32'(timeout), 32'(m_st >= 2));
        check_eq("hung", 32'(hung), 32'(m_st == 3));
        check_eq("missing", 32'(missing), 32'(m_miss));
    endtask

    task automatic wait_timeout(input string tag, input int budget);
        int n;
        n = 0;
        while (timeout !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(timeout), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish, expected finish before limit");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int t;
        int kprob;
        logic [NK-1:0] k;

        reset = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0;
        timeout_load = '0; post_load = '0; kick_mask = '0; kick = '0;
        m_st = 0; now = 0; m_deadline = 0; m_hang_at = 0; m_seen = '0; m_miss = '0;

        repeat (2) tick();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_hung", 32'(hung), 32'd0);
        reset = 1'b0;
        tick();

        // Regular kicks keep the watchdog armed.
        timeout_load = 10; post_load = 5; kick_mask = 4'b0011;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            kick = (c % 5 == 0) ? 4'b0011 : 4'b0000;
            tick();
        end
        kick = '0;
        check_eq("kicked_timeout", 32'(timeout), 32'd0);
        check_eq("kicked_state", 32'(state), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("stop_idle", 32'(state), 32'd0);

        // Only requester 0 kicks: expiry lands on cycle 12 after start.
        start = 1'b1; tick(); start = 1'b0;
        cyc = 1;
        while (timeout !== 1'b1 && cyc < 40) begin
            kick = (cyc % 3 == 0) ? 4'b0001 : 4'b0000;
            tick();
            cyc++;
        end
        kick = '0;
        check_eq("expire_cycle", 32'(cyc), 32'd12);
        check_eq("expire_missing", 32'(missing), MISS_EN ? 32'h2 : 32'h0);

        // No ack: hung six cycles after timeout rises, then ack/start/stop are ignored.
        t = 0;
        while (hung !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check_eq("hung_delay", 32'(t), 32'd6);
        ack = 1'b1; tick(); ack = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("hung_sticky_state", 32'(state), 32'd3);
        check_eq("hung_sticky_flag", 32'(hung), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("hung_reset_state", 32'(state), 32'd0);

        // Ack two cycles after expiry returns to idle; re-arm clears missing.
        timeout_load = 3; kick_mask = 4'b0011; post_load = 5;
        start = 1'b1; tick(); start = 1'b0;
        wait_timeout("ack_case_expire", 20);
        tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("ack_state", 32'(state), 32'd0);
        check_eq("ack_timeout", 32'(timeout), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("rearm_missing", 32'(missing), 32'd0);
        check_eq("rearm_state", 32'(state), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;

        // Completing kick on the counter==0 cycle reloads instead of expiring.
        timeout_load = 4;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        kick = 4'b0011; tick(); kick = '0;
        check_eq("lastkick_state", 32'(state), 32'd1);
        check_eq("lastkick_timeout", 32'(timeout), 32'd0);
        wait_timeout("lastkick_expire", 20);
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("rst_exp_state", 32'(state), 32'd0);
        check_eq("rst_exp_timeout", 32'(timeout), 32'd0);
        check_eq("rst_exp_missing", 32'(missing), 32'd0);

        // Zero reload expires on the first armed cycle.
        timeout_load = 0;
        start = 1'b1; tick(); start = 1'b0;
        check_eq("zero_load_c1", 32'(timeout), 32'd0);
        tick();
        check_eq("zero_load_c2", 32'(timeout), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("exp_stop_state", 32'(state), 32'd0);

        // Empty mask never reloads even with constant kicks.
        kick_mask = 4'b0000; timeout_load = 2;
        start = 1'b1; tick(); start = 1'b0;
        kick = 4'hF;
        repeat (3) tick();
        kick = '0;
        check_eq("mask0_timeout", 32'(timeout), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;

        // Stop beats start in the same cycle.
        timeout_load = 20; kick_mask = 4'b0001;
        start = 1'b1; tick();
        stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0;
        check_eq("stop_wins", 32'(state), 32'd0);

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            if (m_st == 3) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end
            timeout_load = $urandom_range(0, 12);
            post_load    = PW'($urandom_range(0, 6));
            kick_mask    = ($urandom_range(0, 7) == 0) ? 4'b0000 : NK'($urandom_range(1, 15));
            kprob        = $urandom_range(0, 100);
            start = 1'b1; tick(); start = 1'b0;
            for (int c = 0; c < 60; c++) begin
                for (int b = 0; b < NK; b++) k[b] = ($urandom_range(0, 99) < kprob);
                kick  = k;
                stop  = ($urandom_range(0, 99) < 2);
                ack   = ($urandom_range(0, 99) < 5);
                start = ($urandom_range(0, 99) < 3);
                reset = ($urandom_range(0, 99) < 1);
                tick();
            end
            kick = '0; stop = 1'b0; ack = 1'b0; start = 1'b0; reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/watchdog_sequencer.md
WATCHDOG_SEQUENCER -- requirements
Module: watchdog_sequencer

Interface
REQ-001 SHALL have parameter NUM_KICKERS, default 4, number of heartbeat requesters.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, width of the time-out counter.
REQ-003 SHALL have parameter POST_COUNTER_WIDTH, default 8, width of the post time-out counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  arm pulse: load counter, clear kick record.
REQ-007 SHALL have port stop  input  1  disarm pulse: return to IDLE.
REQ-008 SHALL have port timeout_load  input  COUNTER_WIDTH  time-out reload value, in cycles.
REQ-009 SHALL have port post_load  input  POST_COUNTER_WIDTH  grace period after time-out, in cycles.
REQ-010 SHALL have port kick_mask  input  NUM_KICKERS  requesters that must kick in each window.
REQ-011 SHALL have port kick  input  NUM_KICKERS  per-requester heartbeat pulses.
REQ-012 SHALL have port ack  input  1  test bench acknowledges the time-out.
REQ-013 SHALL have port timeout  output  1  time-out flagged (EXPIRED or HUNG).
REQ-014 SHALL have port hung  output  1  grace period elapsed without ack; sticky.
REQ-015 SHALL have port state  output  2  IDLE=0, ARMED=1, EXPIRED=2, HUNG=3.
REQ-016 SHALL have port missing  output  NUM_KICKERS  masked requesters that had not kicked at expiry.

Function
REQ-017 All outputs SHALL be registered; timeout SHALL equal 1 exactly when state is EXPIRED or HUNG.
REQ-018 IDLE: start SHALL move to ARMED next cycle, load counter with timeout_load, and clear the seen register.
REQ-019 ARMED: counter SHALL decrement by 1 per cycle; seen SHALL accumulate kick & kick_mask.
REQ-020 ARMED: if ((seen | kick) & kick_mask) == kick_mask and kick_mask != 0, counter SHALL reload from timeout_load and seen SHALL clear next cycle.
REQ-021 ARMED: if counter == 0 and REQ-020 does not hold, state SHALL become EXPIRED next cycle, post counter SHALL load post_load, and missing SHALL capture kick_mask & ~(seen | kick).
REQ-022 Reload SHALL take priority over expiry in the same cycle; kick_mask == 0 SHALL never reload.
REQ-023 timeout_load == 0 at start SHALL expire on the first ARMED cycle, so timeout is high 2 cycles after start.
REQ-024 start while ARMED SHALL restart the window (reload, clear seen); start SHALL be ignored in EXPIRED and HUNG.
REQ-025 EXPIRED: post counter SHALL decrement by 1 per cycle; ack or stop SHALL return to IDLE next cycle and clear timeout.
REQ-026 EXPIRED: post counter == 0 without ack or stop SHALL move to HUNG; hung SHALL be 1 in HUNG.
REQ-027 HUNG SHALL be left only by reset; start, stop and ack SHALL be ignored there.
REQ-028 stop in ARMED SHALL return to IDLE; stop and start in the same cycle: stop SHALL win.
REQ-029 Counter arithmetic SHALL be unsigned and SHALL NOT wrap below 0.

Reset
REQ-030 Reset SHALL force state=IDLE, timeout=0, hung=0, missing=0, counter=0, post counter=0, seen=0, overriding every other input, including mid-EXPIRED.

Configuration
REQ-031 With macro WATCHDOG_MISSING_EN defined, missing SHALL behave per REQ-021 and clear on the next start or reset.
REQ-032 Without WATCHDOG_MISSING_EN, missing SHALL be tied to 0 and the capture logic SHALL be omitted; all other behaviour SHALL be identical.

Verification
REQ-033 timeout_load=10, kick_mask=4'b0011, kick[0] and kick[1] every 5 cycles for 100 cycles -> timeout stays 0, state=1.
REQ-034 timeout_load=10, kick_mask=4'b0011, only kick[0] pulses -> timeout=1 at cycle 12 after start, missing=4'b0010 (macro on).
REQ-035 post_load=5, no ack after expiry -> hung=1 and state=3 six cycles after timeout rises; ack afterwards has no effect.
REQ-036 Expiry, then ack 2 cycles later -> state=0 and timeout=0 next cycle; start then re-arms with missing=0.
REQ-037 Final kick on the cycle counter==0 -> reload, no expiry; reset asserted in EXPIRED -> all outputs 0 next cycle.
